// File: rtl/gray_adaptive_threshold.sv
// gray_adaptive_threshold: binarises an 8-bit grayscale stream against either a fixed
// threshold or the previous frame's mean luminance plus a signed offset. The mean is
// produced by a per-frame accumulator feeding a restoring divider that runs in blanking.
module gray_adaptive_threshold #(
   parameter int FRAME_PIXELS   = 384000,
   parameter int SUM_W          = 27,
   parameter int DEFAULT_THRESH = 128
) (
   input  logic       iClk,
   input  logic       iRst_n,
   input  logic       iGray_valid,
   input  logic [7:0] iGray,
   input  logic       iFrame_start,
   input  logic       iMode,
   input  logic [7:0] iFixed_thresh,
   input  logic [7:0] iOffset,
   input  logic       iInvert,
   output logic       oThresh_valid,
   output logic [7:0] oThresh,
   output logic [7:0] oLevel,
   output logic       oFrame_done
);

   localparam int CNT_W = $clog2(FRAME_PIXELS + 1);
   localparam int BIT_W = $clog2(SUM_W + 1);
   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME_PIXELS - 1);
   localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(SUM_W - 1);
   localparam logic [BIT_W-1:0] ONE_BIT   = BIT_W'(1);
   localparam logic [SUM_W:0]   DIVISOR   = (SUM_W + 1)'(FRAME_PIXELS);
   localparam logic [7:0]       DEF_LEVEL = 8'(DEFAULT_THRESH);

   typedef enum logic [1:0] {
      IDLE_ACC,
      DIVIDE,
      LOAD
   } state_t;

   // reset synchroniser: assertion passes straight through, release is aligned to iClk
   logic [1:0] rst_sync_q;
   logic       rst_n;

   // two-flop release synchroniser for the asynchronous reset
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_n = rst_sync_q[1];

   // pipeline, accumulator and divider state
   logic [7:0]       pix1_q, pix1_d;
   logic             vld1_q, vld1_d;
   logic [7:0]       thr1_q, thr1_d;
   logic [7:0]       level_q, level_d;
   logic [7:0]       thresh_q, thresh_d;
   logic             thresh_valid_q, thresh_valid_d;
   logic [SUM_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   state_t           state_q, state_d;
   logic [SUM_W-1:0] dq_q, dq_d;
   logic [SUM_W-1:0] rem_q, rem_d;
   logic [BIT_W-1:0] bit_q, bit_d;
   logic [7:0]       mean_q, mean_d;
   logic             done_q, done_d;

   logic [SUM_W-1:0] gray_ext;
   logic [SUM_W-1:0] snap_val;
   logic             snap_fire;
   logic signed [9:0] offset_sum;
   logic [7:0]       adapt_thr;
   logic [7:0]       thr_sel;
   logic [SUM_W:0]   rem_shift;
   logic [SUM_W:0]   rem_diff;
   logic             q_bit;
   logic             unused_rem_msb;

   assign gray_ext = {{(SUM_W - 8){1'b0}}, iGray};
   assign snap_val = acc_q + gray_ext;

   // threshold selection: fixed register or saturated (mean + signed offset)
   always_comb begin
      offset_sum = $signed({2'b00, mean_q}) + $signed({{2{iOffset[7]}}, iOffset});
      adapt_thr  = offset_sum[7:0];
      if (offset_sum < 0) begin
         adapt_thr = 8'h00;
      end else if (offset_sum > 10'sd255) begin
         adapt_thr = 8'hFF;
      end
      thr_sel = iMode ? adapt_thr : iFixed_thresh;
   end

   // two-stage compare pipeline; output forced low whenever the qualifier is low
   always_comb begin
      pix1_d         = iGray;
      vld1_d         = iGray_valid;
      thr1_d         = thr_sel;
      level_d        = thr1_q;
      thresh_valid_d = vld1_q;
      thresh_d       = 8'h00;
      if (vld1_q && ((pix1_q >= thr1_q) ^ iInvert)) begin
         thresh_d = 8'hFF;
      end
   end

   // per-frame accumulation; frame start resynchronises, last pixel hands a snapshot over
   always_comb begin
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      snap_fire = 1'b0;
      if (iFrame_start) begin
         if (iGray_valid) begin
            acc_d = gray_ext;
            cnt_d = ONE_CNT;
         end else begin
            acc_d = '0;
            cnt_d = '0;
         end
      end else if (iGray_valid) begin
         if (cnt_q == LAST_CNT) begin
            snap_fire = 1'b1;
            acc_d     = '0;
            cnt_d     = '0;
         end else begin
            acc_d = snap_val;
            cnt_d = cnt_q + ONE_CNT;
         end
      end
   end

   // mean FSM: restoring division of the snapshot, one quotient bit per cycle, then load
   always_comb begin
      state_d   = state_q;
      dq_d      = dq_q;
      rem_d     = rem_q;
      bit_d     = bit_q;
      mean_d    = mean_q;
      done_d    = 1'b0;
      rem_shift = {rem_q, dq_q[SUM_W-1]};
      rem_diff  = rem_shift - DIVISOR;
      q_bit     = (rem_shift >= DIVISOR);
      case (state_q)
         IDLE_ACC: begin
            if (snap_fire) begin
               state_d = DIVIDE;
               dq_d    = snap_val;
               rem_d   = '0;
               bit_d   = '0;
            end
         end
         DIVIDE: begin
            rem_d = q_bit ? rem_diff[SUM_W-1:0] : rem_shift[SUM_W-1:0];
            dq_d  = {dq_q[SUM_W-2:0], q_bit};
            bit_d = bit_q + ONE_BIT;
            if (bit_q == LAST_BIT) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            mean_d  = (|dq_q[SUM_W-1:8]) ? 8'hFF : dq_q[7:0];
            done_d  = 1'b1;
            state_d = IDLE_ACC;
         end
         default: begin
            state_d = IDLE_ACC;
         end
      endcase
   end

   assign unused_rem_msb = rem_diff[SUM_W];

   // all state registers share the synchronised asynchronous reset
   always_ff @(posedge iClk or negedge rst_n) begin
      if (!rst_n) begin
         pix1_q         <= 8'h00;
         vld1_q         <= 1'b0;
         thr1_q         <= DEF_LEVEL;
         level_q        <= DEF_LEVEL;
         thresh_q       <= 8'h00;
         thresh_valid_q <= 1'b0;
         acc_q          <= '0;
         cnt_q          <= '0;
         state_q        <= IDLE_ACC;
         dq_q           <= '0;
         rem_q          <= '0;
         bit_q          <= '0;
         mean_q         <= DEF_LEVEL;
         done_q         <= 1'b0;
      end else begin
         pix1_q         <= pix1_d;
         vld1_q         <= vld1_d;
         thr1_q         <= thr1_d;
         level_q        <= level_d;
         thresh_q       <= thresh_d;
         thresh_valid_q <= thresh_valid_d;
         acc_q          <= acc_d;
         cnt_q          <= cnt_d;
         state_q        <= state_d;
         dq_q           <= dq_d;
         rem_q          <= rem_d;
         bit_q          <= bit_d;
         mean_q         <= mean_d;
         done_q         <= done_d;
      end
   end

   assign oThresh_valid = thresh_valid_q;
   assign oThresh       = thresh_q;
   assign oLevel        = level_q;
   assign oFrame_done   = done_q;

endmodule

// File: tb/tb_gray_adaptive_threshold.sv
// tb_gray_adaptive_threshold: directed bench for the grayscale threshold block with a
// 16-pixel frame so adaptive means can be hand-computed.
module tb_gray_adaptive_threshold;

   localparam int FRAME_PIXELS   = 16;
   localparam int SUM_W          = 12;
   localparam int DEFAULT_THRESH = 128;

   logic       iClk;
   logic       iRst_n;
   logic       iGray_valid;
   logic [7:0] iGray;
   logic       iFrame_start;
   logic       iMode;
   logic [7:0] iFixed_thresh;
   logic [7:0] iOffset;
   logic       iInvert;
   logic       oThresh_valid;
   logic [7:0] oThresh;
   logic [7:0] oLevel;
   logic       oFrame_done;

   int n_checks;
   int n_pass;
   int done_seen;

   gray_adaptive_threshold #(
      .FRAME_PIXELS  (FRAME_PIXELS),
      .SUM_W         (SUM_W),
      .DEFAULT_THRESH(DEFAULT_THRESH)
   ) dut (
      .iClk         (iClk),
      .iRst_n       (iRst_n),
      .iGray_valid  (iGray_valid),
      .iGray        (iGray),
      .iFrame_start (iFrame_start),
      .iMode        (iMode),
      .iFixed_thresh(iFixed_thresh),
      .iOffset      (iOffset),
      .iInvert      (iInvert),
      .oThresh_valid(oThresh_valid),
      .oThresh      (oThresh),
      .oLevel       (oLevel),
      .oFrame_done  (oFrame_done)
   );

   // free-running pixel clock
   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic apply_pixel(input logic [7:0] px);
      iGray_valid = 1'b1;
      iGray       = px;
      tick();
   endtask

   task automatic apply_idle();
      iGray_valid = 1'b0;
      iGray       = 8'hFF;
      tick();
   endtask

   task automatic apply_frame_start();
      iGray_valid  = 1'b0;
      iFrame_start = 1'b1;
      tick();
      iFrame_start = 1'b0;
   endtask

   task automatic apply_frame(input logic [7:0] px);
      for (int i = 0; i < FRAME_PIXELS; i++) apply_pixel(px);
      iGray_valid = 1'b0;
   endtask

   task automatic check_done_pulse(input string tag);
      iGray_valid = 1'b0;
      repeat (SUM_W) tick();
      check_output({tag, "_early"}, 32'(oFrame_done), 32'd0);
      tick();
      check_output({tag, "_pulse"}, 32'(oFrame_done), 32'd1);
      tick();
      check_output({tag, "_end"}, 32'(oFrame_done), 32'd0);
   endtask

   // linear sequence of directed steps
   initial begin
      n_checks      = 0;
      n_pass        = 0;
      iRst_n        = 1'b0;
      iGray_valid   = 1'b0;
      iGray         = 8'h00;
      iFrame_start  = 1'b0;
      iMode         = 1'b0;
      iFixed_thresh = 8'd0;
      iOffset       = 8'd0;
      iInvert       = 1'b0;

      // reset values
      repeat (3) tick();
      check_output("rst_level", 32'(oLevel), 32'd128);
      check_output("rst_valid", 32'(oThresh_valid), 32'd0);
      check_output("rst_thresh", 32'(oThresh), 32'd0);
      check_output("rst_done", 32'(oFrame_done), 32'd0);
      #2 iRst_n = 1'b1;
      repeat (3) tick();

      // fixed threshold, normal polarity
      iFixed_thresh = 8'd100;
      repeat (3) tick();
      check_output("fix_level", 32'(oLevel), 32'd100);
      apply_pixel(8'd99);
      apply_pixel(8'd100);
      check_output("fix_99_valid", 32'(oThresh_valid), 32'd1);
      check_output("fix_99", 32'(oThresh), 32'h00);
      apply_pixel(8'd101);
      check_output("fix_100", 32'(oThresh), 32'hFF);
      apply_idle();
      check_output("fix_101", 32'(oThresh), 32'hFF);
      apply_idle();
      check_output("fix_idle_valid", 32'(oThresh_valid), 32'd0);
      check_output("fix_idle_thresh", 32'(oThresh), 32'h00);

      // fixed threshold, inverted polarity
      iInvert = 1'b1;
      apply_pixel(8'd99);
      apply_pixel(8'd100);
      check_output("inv_99", 32'(oThresh), 32'hFF);
      apply_pixel(8'd101);
      check_output("inv_100", 32'(oThresh), 32'h00);
      apply_idle();
      check_output("inv_101", 32'(oThresh), 32'h00);
      apply_idle();
      check_output("inv_idle_thresh", 32'(oThresh), 32'h00);
      iInvert = 1'b0;

      // adaptive: 16 pixels of 60 give mean 60
      apply_frame_start();
      apply_frame(8'd60);
      check_done_pulse("ad60_done");
      iMode   = 1'b1;
      iOffset = 8'd0;
      repeat (3) tick();
      check_output("ad60_level", 32'(oLevel), 32'd60);
      apply_pixel(8'd59);
      apply_pixel(8'd60);
      check_output("ad60_59", 32'(oThresh), 32'h00);
      apply_idle();
      check_output("ad60_60", 32'(oThresh), 32'hFF);
      apply_idle();

      // offset saturation high: mean 250 + 20
      apply_frame_start();
      apply_frame(8'd250);
      check_done_pulse("ad250_done");
      iOffset = 8'h14;
      repeat (3) tick();
      check_output("sat_hi", 32'(oLevel), 32'd255);
      iOffset = 8'h00;
      repeat (3) tick();
      check_output("mean250", 32'(oLevel), 32'd250);

      // offset saturation low: mean 5 - 20, plus exact zero and small positive offsets
      apply_frame_start();
      apply_frame(8'd5);
      check_done_pulse("ad5_done");
      iOffset = 8'hEC;
      repeat (3) tick();
      check_output("sat_lo", 32'(oLevel), 32'd0);
      iOffset = 8'hFB;
      repeat (3) tick();
      check_output("off_m5", 32'(oLevel), 32'd0);
      iOffset = 8'h03;
      repeat (3) tick();
      check_output("off_p3", 32'(oLevel), 32'd8);
      iOffset = 8'h00;

      // resync: partial frame discarded, coincident pixel counts as pixel 0
      apply_frame_start();
      for (int i = 0; i < 7; i++) apply_pixel(8'd50);
      iFrame_start = 1'b1;
      apply_pixel(8'd200);
      iFrame_start = 1'b0;
      for (int i = 0; i < FRAME_PIXELS - 1; i++) apply_pixel(8'd0);
      check_done_pulse("resync_done");
      repeat (3) tick();
      check_output("resync_mean", 32'(oLevel), 32'd12);

      // back-to-back: frame B (with gaps) streams while frame A divides
      apply_frame_start();
      apply_frame(8'd40);
      for (int i = 0; i < FRAME_PIXELS; i++) begin
         apply_pixel(8'd80);
         if (i == 6) check_output("b2b_done_a", 32'(oFrame_done), 32'd1);
         if (i < FRAME_PIXELS - 1) apply_idle();
      end
      check_output("b2b_mean_a", 32'(oLevel), 32'd40);
      check_done_pulse("b2b_done_b");
      repeat (3) tick();
      check_output("b2b_mean_b", 32'(oLevel), 32'd80);

      // asynchronous reset mid-stream
      apply_pixel(8'd200);
      apply_pixel(8'd200);
      check_output("pre_rst_valid", 32'(oThresh_valid), 32'd1);
      #3 iRst_n = 1'b0;
      #1;
      check_output("arst_level", 32'(oLevel), 32'd128);
      check_output("arst_valid", 32'(oThresh_valid), 32'd0);
      check_output("arst_thresh", 32'(oThresh), 32'h00);
      check_output("arst_done", 32'(oFrame_done), 32'd0);
      iGray_valid = 1'b0;
      tick();
      iRst_n = 1'b1;
      repeat (4) tick();

      // reset during division aborts it; level stays at the default
      apply_frame_start();
      apply_frame(8'd100);
      repeat (5) tick();
      iRst_n = 1'b0;
      tick();
      iRst_n = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (oFrame_done === 1'b1) done_seen++;
      end
      check_output("abort_no_done", 32'(done_seen), 32'd0);
      check_output("abort_level", 32'(oLevel), 32'd128);

      $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
